// File: rtl/dsp_pkg.sv
// -----------------------------------------------------------------------------
// dsp_pkg
// Shared definitions for the DSP chain (FIR filter, decimator, later stages).
//
// Contents:
//   DATA_W         sample width used throughout the chain
//   sample_t       signed sample type
//   DECIM_DEFAULT  default decimation factor
//   acc_width()    width of a boxcar accumulator that cannot overflow
// -----------------------------------------------------------------------------
package dsp_pkg;

    localparam int DATA_W        = 16;
    localparam int DECIM_DEFAULT = 4;

    typedef logic signed [DATA_W-1:0] sample_t;

    // Summing 'count' samples of 'data_w' bits needs log2(count) guard bits.
    function automatic int acc_width(input int data_w, input int count);
        return data_w + $clog2(count);
    endfunction

endpackage

// File: rtl/dsp_sync_fifo.sv
// -----------------------------------------------------------------------------
// dsp_sync_fifo
// Single-clock FIFO with registered storage, reused by several DSP stages.
// Full/empty come from an occupancy counter; pointers wrap modulo DEPTH.
// A push while full is accepted only if a pop happens in the same cycle.
// A pop while empty is ignored.
//
// Parameters:
//   DEPTH  number of entries (power of two, >= 2)
//   WIDTH  entry width
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset, empties the FIFO
//   push       in   write push_data this cycle
//   push_data  in   WIDTH  data to write
//   pop        in   remove head entry this cycle
//   head       out  WIDTH  current head entry
//   full       out  level == DEPTH
//   empty      out  level == 0
//   level      out  $clog2(DEPTH)+1  current occupancy
// -----------------------------------------------------------------------------
module dsp_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == DEPTH_LVL);
    assign empty   = (level == '0);
    assign do_pop  = pop && !empty;
    // When full, the slot under wr_ptr is the head being popped, so it can
    // be overwritten in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/fir_decimator.sv
// -----------------------------------------------------------------------------
// fir_decimator
// Boxcar accumulate-and-dump decimator following the 4-tap FIR. Every DECIM
// valid samples it emits their mean (arithmetic shift, rounds toward -inf)
// into an output FIFO with a valid/ready handshake. Results arriving while
// the FIFO is full and not being popped are dropped and flagged in ovf.
//
// Optional feature (macro FIR_DECIMATOR_DROP_CNT_EN):
//   adds drop_cnt, a saturating count of dropped results cleared by ovf_clr.
//
// Parameters:
//   DATA_W      sample width, must equal dsp_pkg::DATA_W
//   DECIM       decimation factor, power of two, 2..64
//   FIFO_DEPTH  output FIFO entries, power of two, >= 2
//
// Ports:
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   in_valid    in   in_data valid this cycle (no upstream backpressure)
//   in_data     in   DATA_W  signed filtered sample
//   out_valid   out  FIFO head holds a result
//   out_ready   in   consumer accepts head this cycle
//   out_data    out  DATA_W  signed decimated sample (FIFO head)
//   ovf         out  sticky: a result was dropped
//   ovf_clr     in   synchronous clear of ovf (and drop_cnt)
//   fifo_level  out  current FIFO occupancy
//   drop_cnt    out  16  dropped-result count (only with the macro)
// -----------------------------------------------------------------------------
module fir_decimator
    import dsp_pkg::*;
#(
    parameter int DATA_W     = dsp_pkg::DATA_W,
    parameter int DECIM      = DECIM_DEFAULT,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    input  logic [DATA_W-1:0]             in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_W-1:0]             out_data,
    output logic                          ovf,
    input  logic                          ovf_clr,
`ifdef FIR_DECIMATOR_DROP_CNT_EN
    output logic [15:0]                   drop_cnt,
`endif
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int SHIFT   = $clog2(DECIM);
    localparam int ACC_W   = acc_width(DATA_W, DECIM);
    localparam int PHASE_W = SHIFT;
    localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(DECIM - 1);

    logic [PHASE_W-1:0]      phase;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] in_ext;
    logic signed [ACC_W-1:0] sum;
    logic                    dump;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    drop;

    assign in_ext = $signed({{SHIFT{in_data[DATA_W-1]}}, in_data});
    assign sum    = acc + in_ext;
    assign dump   = in_valid && (phase == LAST_PHASE);
    // Full with no pop this cycle means the fresh result has nowhere to go.
    assign drop   = dump && fifo_full && !out_ready;

    // Phase counter and accumulator; idle cycles simply hold state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= '0;
            acc   <= '0;
        end else if (in_valid) begin
            if (dump) begin
                phase <= '0;
                acc   <= '0;
            end else begin
                phase <= phase + PHASE_W'(1);
                acc   <= sum;
            end
        end
    end

    // Sticky overflow flag; a new drop wins over a clear in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (drop) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end

`ifdef FIR_DECIMATOR_DROP_CNT_EN
    // Saturating drop counter; a drop coinciding with a clear restarts at 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (ovf_clr) begin
            drop_cnt <= drop ? 16'd1 : 16'd0;
        end else if (drop && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end
`endif

    // The upper DATA_W bits of the sum are the sum arithmetically shifted by
    // log2(DECIM), i.e. the mean rounded toward -inf.
    dsp_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (dump),
        .push_data (sum[ACC_W-1:SHIFT]),
        .pop       (out_ready),
        .head      (out_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign out_valid = !fifo_empty;

endmodule

// File: tb/tb_fir_decimator.sv
// -----------------------------------------------------------------------------
// tb_fir_decimator
// Directed self-checking bench for fir_decimator (DECIM=4, FIFO_DEPTH=4).
// Inputs change 1 ns after each rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_fir_decimator;

    localparam int DATA_W     = 16;
    localparam int DECIM      = 4;
    localparam int FIFO_DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic              ovf;
    logic              ovf_clr = 1'b0;
    logic [2:0]        fifo_level;
`ifdef FIR_DECIMATOR_DROP_CNT_EN
    logic [15:0]       drop_cnt;
`endif

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    fir_decimator #(
        .DATA_W     (DATA_W),
        .DECIM      (DECIM),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .ovf        (ovf),
        .ovf_clr    (ovf_clr),
`ifdef FIR_DECIMATOR_DROP_CNT_EN
        .drop_cnt   (drop_cnt),
`endif
        .fifo_level (fifo_level)
    );

    // Drive one cycle of input, then move to 1 ns past the next rising edge.
    task automatic applyStimulus(input logic v, input int d);
        in_valid = v;
        in_data  = DATA_W'(d);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic checkOutput(input string tag,
                               input logic signed [31:0] observed,
                               input logic signed [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic checkAll(input string tag, input int v, input int d,
                            input int lvl, input int o);
        checkOutput({tag, ".out_valid"}, 32'(out_valid), v);
        checkOutput({tag, ".out_data"}, 32'($signed(out_data)), d);
        checkOutput({tag, ".fifo_level"}, 32'(fifo_level), lvl);
        checkOutput({tag, ".ovf"}, 32'(ovf), o);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        $display("[TB] start");
        // Reset state
        #3;
        checkAll("reset", 0, 0, 0, 0);
`ifdef FIR_DECIMATOR_DROP_CNT_EN
        checkOutput("reset.drop_cnt", 32'(drop_cnt), 0);
`endif
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1,2,3,4 -> 2, single pulse the cycle after the 4th input
        out_ready = 1'b1;
        applyStimulus(1'b1, 1);
        applyStimulus(1'b1, 2);
        applyStimulus(1'b1, 3);
        checkOutput("basic.no_early_valid", 32'(out_valid), 0);
        applyStimulus(1'b1, 4);
        checkAll("basic.result", 1, 2, 1, 0);
        applyStimulus(1'b0, 0);
        checkOutput("basic.single_pulse", 32'(out_valid), 0);

        // -1,-1,-1,-2 -> -5>>>2 = -2
        applyStimulus(1'b1, -1);
        applyStimulus(1'b1, -1);
        applyStimulus(1'b1, -1);
        applyStimulus(1'b1, -2);
        checkOutput("neg.out_data", 32'($signed(out_data)), -2);
        applyStimulus(1'b0, 0);

        // Full-scale positive and negative
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32767);
        checkOutput("maxpos.out_data", 32'($signed(out_data)), 32767);
        applyStimulus(1'b0, 0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, -32768);
        checkOutput("maxneg.out_data", 32'($signed(out_data)), -32768);
        applyStimulus(1'b0, 0);

        // Gapped input 8,x,x,8,8,x,8 -> 8
        applyStimulus(1'b1, 8);
        applyStimulus(1'b0, 1234);
        applyStimulus(1'b0, 1234);
        applyStimulus(1'b1, 8);
        applyStimulus(1'b1, 8);
        applyStimulus(1'b0, 1234);
        checkOutput("gap.no_early_valid", 32'(out_valid), 0);
        applyStimulus(1'b1, 8);
        checkAll("gap.result", 1, 8, 1, 0);
        applyStimulus(1'b0, 0);

        // Backpressure: 20 groups of 5 with out_ready=0
        out_ready = 1'b0;
        for (int g = 0; g < 4; g++) begin
            for (int i = 0; i < 4; i++) applyStimulus(1'b1, 5);
        end
        checkAll("stall.after4", 1, 5, 4, 0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 5);
        checkAll("stall.after5", 1, 5, 4, 1);
        for (int g = 5; g < 20; g++) begin
            for (int i = 0; i < 4; i++) applyStimulus(1'b1, 5);
        end
        checkAll("stall.after20", 1, 5, 4, 1);
`ifdef FIR_DECIMATOR_DROP_CNT_EN
        checkOutput("stall.drop_cnt", 32'(drop_cnt), 16);
`endif
        ovf_clr = 1'b1;
        applyStimulus(1'b0, 0);
        ovf_clr = 1'b0;
        checkAll("ovf_clr", 1, 5, 4, 0);
`ifdef FIR_DECIMATOR_DROP_CNT_EN
        checkOutput("ovf_clr.drop_cnt", 32'(drop_cnt), 0);
`endif

        // Full FIFO, pop coincides with the 4th sample of a group of 6s
        applyStimulus(1'b1, 6);
        applyStimulus(1'b1, 6);
        applyStimulus(1'b1, 6);
        out_ready = 1'b1;
        applyStimulus(1'b1, 6);
        checkAll("fullpop", 1, 5, 4, 0);
        applyStimulus(1'b0, 0);
        checkAll("drain1", 1, 5, 3, 0);
        applyStimulus(1'b0, 0);
        checkAll("drain2", 1, 5, 2, 0);
        applyStimulus(1'b0, 0);
        checkAll("drain3", 1, 6, 1, 0);
        applyStimulus(1'b0, 0);
        checkOutput("drain4.out_valid", 32'(out_valid), 0);
        checkOutput("drain4.fifo_level", 32'(fifo_level), 0);

        // Reset with one queued result and a partial group of 100s
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 7);
        applyStimulus(1'b1, 100);
        applyStimulus(1'b1, 100);
        checkOutput("prereset.fifo_level", 32'(fifo_level), 1);
        #2 rst_n = 1'b0;
        #1;
        checkAll("async_reset", 0, 0, 0, 0);
        @(posedge clk);
        #4 rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 4);
        checkAll("postreset.result", 1, 4, 1, 0);
        applyStimulus(1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fir_decimator.md
Name: fir_decimator

Overview:
- Downstream stage of the 4-tap FIR filter.
- Consumes the filtered sample stream and performs boxcar accumulate-and-dump decimation by DECIM, producing the mean of each group of DECIM samples.
- Buffers results in a small FIFO with a valid/ready output handshake, so a slower consumer (DAC or serializer) can apply backpressure.
- Reports overflow when results are lost because that consumer stalls.

Parameters:
- DATA_W, 16, sample width (signed two's complement); must equal dsp_pkg sample width.
- DECIM, 4, decimation factor; power of two, 2..64.
- FIFO_DEPTH, 4, output FIFO entries; power of two, >=2.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset; one clock, asynchronous active-low reset.
- in_valid  input  1  in_data valid this cycle; no backpressure upstream.
- in_data  input  DATA_W  signed filtered sample from FIR.
- out_valid  output  1  FIFO head holds a result.
- out_ready  input  1  consumer accepts head this cycle.
- out_data  output  DATA_W  signed decimated sample (FIFO head).
- ovf  output  1  sticky: a result was dropped because the FIFO was full.
- ovf_clr  input  1  synchronous clear of ovf.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (async assert, sync deassert assumed upstream): phase=0, acc=0, FIFO empty, out_valid=0, out_data=0, ovf=0, fifo_level=0.
- Reset mid-group discards the partial accumulation. Reset with a non-empty FIFO discards all contents.
- Accumulator width: DATA_W + log2(DECIM), signed; the input is sign-extended, so no overflow is possible.
- Each accepted input (in_valid=1):
  - If phase < DECIM-1: acc += in_data; phase++.
  - If phase == DECIM-1: result = (acc + in_data) >>> log2(DECIM), an arithmetic shift that truncates toward -inf. Push the result's low DATA_W bits to the FIFO, reset acc=0 and phase=0.
- in_valid=0: acc and phase hold. Gaps of any length are legal.
- FIFO is registered storage; out_data is the head entry, driven from a register.
- Latency: the result pushed at the edge of the DECIM-th valid input is visible (out_valid=1) in the following cycle if the FIFO was empty.
- Pop occurs when out_valid && out_ready. out_data must be stable while out_valid=1 and out_ready=0.
- Push with the FIFO full and no pop in the same cycle: the result is dropped, ovf set to 1, and FIFO contents are unchanged.
- Push with the FIFO full plus a simultaneous pop: the push is accepted and the level stays at FIFO_DEPTH, so no overflow.
- Push and pop in the same cycle when not full: level unchanged.
- Pop when empty: ignored (out_valid=0).
- ovf_clr and a new overflow in the same cycle: ovf stays 1 (set wins).
- Read and write pointers wrap modulo FIFO_DEPTH. Full/empty are derived from the level counter.

Optional Feature:
- Macro: FIR_DECIMATOR_DROP_CNT_EN.
- Defined: adds output drop_cnt [15:0].
  - Increments on every dropped result and saturates at 16'hFFFF.
  - Cleared by ovf_clr (if a drop coincides with ovf_clr, drop_cnt = 1).
  - Reset value 0.
- Undefined: the port and counter are absent. ovf behaviour is identical in both cases.

Decomposition:
- dsp_pkg:
  - DATA_W constant (16) and typedef sample_t (logic signed [DATA_W-1:0]).
  - Function clog2-based helper for accumulator width.
  - Constant DECIM_DEFAULT=4.
- Sub-module dsp_sync_fifo (DEPTH, WIDTH parameters):
  - Push/pop, full/empty/level outputs.
  - Same clk/rst_n convention.
  - Reused by other DSP stages.
- fir_decimator contains the phase counter, accumulator, drop/ovf logic and the FIFO instance.

Test Plan (DECIM=4, FIFO_DEPTH=4):
- Inputs 1,2,3,4 with out_ready=1 -> one output 2 (10>>>2), out_valid the cycle after the 4th input, exactly one pulse.
- Inputs -1,-1,-1,-2 -> output -2 (-5>>>2 truncates toward -inf). Four x 32767 -> 32767. Four x -32768 -> -32768.
- in_valid toggling 1,0,0,1,1,0,1 with data 8,x,x,8,8,x,8 -> single output 8; no output before the 4th valid sample.
- out_ready=0, 20 groups of constant 5 -> fifo_level reaches 4, outputs hold at 5, ovf=1 after the 5th group. With DROP_CNT_EN, drop_cnt=16. Then ovf_clr pulse -> ovf=0.
- FIFO full and out_ready=1 in the same cycle as the 4th sample of the next group -> level stays 4, ovf stays 0, data order preserved.
- Feed 2 of 4 samples, assert rst_n=0 asynchronously mid-cycle -> all outputs 0 immediately. After release, inputs 4,4,4,4 -> output 4 (no stale partial sum).
